// File: rtl/image_buffer_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// img_buf_pkg
// Shared types and defaults for the ping-pong image input buffer.
//   bank_state_t : lifecycle of one bank (EMPTY -> FILLING -> READY -> ACTIVE)
//   DEF_*        : default word width, read address width and bank depth
//   addr_bits()  : RAM index width for a given bank depth (minimum 1)
// -----------------------------------------------------------------------------
package img_buf_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    READY   = 2'd2,
    ACTIVE  = 2'd3
  } bank_state_t;

  localparam int DEF_DATA_W = 128;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DEPTH  = 4096;

  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/image_buffer_ctrl_bank_ram.sv
// -----------------------------------------------------------------------------
// dp_bank_ram
// One image bank: DEPTH x DATA_W storage with one write port and two
// independent read ports. Reads are registered (1-cycle latency); the
// contents are not reset.
//   clock          : rising-edge clock
//   we/waddr/wdata : write port
//   raddr0/raddr1  : read addresses, sampled at the rising edge
//   rdata0/rdata1  : registered read data
// -----------------------------------------------------------------------------
module dp_bank_ram #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 4096,
  parameter int AW     = 12
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr0,
  input  logic [AW-1:0]     raddr1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata0 <= mem[raddr0];
    rdata1 <= mem[raddr1];
  end

endmodule

// File: rtl/image_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// image_buffer_ctrl
// Double-buffered image input memory. The host streams the next image into
// bank wr_bank while the engine reads the current image from bank rd_bank.
// A full bank is launched to the idle engine with new_image_pulse and
// input_mem_depth; engine_done recycles it.
//
// Optional feature macro: IMGBUF_OVF_CHECK_EN
//   defined   : an image that reaches DEPTH words without host_wlast sets the
//               sticky overflow_err; the remaining beats up to host_wlast are
//               accepted and dropped.
//   undefined : overflow_err is 0 and the DEPTH-th word simply closes the bank.
//
// Ports
//   clock, reset (sync, active-low)
//   host_wvalid/host_wready/host_wdata/host_wlast : host write stream
//   new_image_pulse, input_mem_depth             : engine launch
//   engine_done                                  : engine finished image
//   input_mem_raddr0/1, input_mem_rdata0/1       : engine reads of rd_bank
//   bank_ready                                   : per-bank READY|ACTIVE
//   overflow_err                                 : sticky truncation flag
//   dbg_bank_state                               : {state bank1, state bank0}
//
// Host write handshake: a beat transfers on a rising edge where both
// host_wvalid and host_wready are high. While host_wvalid is high and
// host_wready is low the host holds host_wdata/host_wlast stable; host_wready
// never depends on host_wvalid.
// -----------------------------------------------------------------------------
module image_buffer_ctrl
  import img_buf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              host_wvalid,
  output logic              host_wready,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_wlast,
  output logic              new_image_pulse,
  output logic [ADDR_W:0]   input_mem_depth,
  input  logic              engine_done,
  input  logic [ADDR_W-1:0] input_mem_raddr0,
  input  logic [ADDR_W-1:0] input_mem_raddr1,
  output logic [DATA_W-1:0] input_mem_rdata0,
  output logic [DATA_W-1:0] input_mem_rdata1,
  output logic [1:0]        bank_ready,
  output logic              overflow_err,
  output logic [3:0]        dbg_bank_state
);

  localparam int              RAM_AW   = addr_bits(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_W  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};

  bank_state_t     state_q [2];
  bank_state_t     state_d [2];
  logic [ADDR_W:0] depth_q [2];
  logic [ADDR_W:0] depth_d [2];
  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
  logic [ADDR_W:0] wcnt_q, wcnt_d;
  logic [ADDR_W:0] mem_depth_q, mem_depth_d;

`ifdef IMGBUF_OVF_CHECK_EN
  logic            ovf_q, ovf_d;
  logic            drop_q, drop_d;  // discarding the tail of a truncated image
`endif

  logic            wr_open;
  logic            beat;
  logic            store;
  logic            at_end;
  logic            close;
  logic            launch;
  logic            done_ok;

  // ---------------------------------------------------------------------------
  // Next-state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d[0]  = state_q[0];
    state_d[1]  = state_q[1];
    depth_d[0]  = depth_q[0];
    depth_d[1]  = depth_q[1];
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wcnt_d      = wcnt_q;
    mem_depth_d = mem_depth_q;

    wr_open = (state_q[wr_bank_q] == EMPTY) || (state_q[wr_bank_q] == FILLING);

`ifdef IMGBUF_OVF_CHECK_EN
    ovf_d       = ovf_q;
    drop_d      = drop_q;
    host_wready = reset && (drop_q || wr_open);
    beat        = host_wvalid && host_wready;
    store       = beat && !drop_q;
`else
    host_wready = reset && wr_open;
    beat        = host_wvalid && host_wready;
    store       = beat;
`endif

    at_end  = (wcnt_q == LAST_IDX);
    close   = store && (host_wlast || at_end);
    // The engine is idle exactly when rd_bank is not ACTIVE, so a READY
    // rd_bank is launched immediately.
    launch  = reset && (state_q[rd_bank_q] == READY);
    done_ok = engine_done && (state_q[rd_bank_q] == ACTIVE);

    new_image_pulse = launch;
    input_mem_depth = launch ? depth_q[rd_bank_q] : mem_depth_q;

    if (store) begin
      wcnt_d = wcnt_q + ONE;
      if (state_q[wr_bank_q] == EMPTY) begin
        state_d[wr_bank_q] = FILLING;
      end
      if (close) begin
        state_d[wr_bank_q] = READY;
        depth_d[wr_bank_q] = wcnt_q + ONE;
        wr_bank_d          = ~wr_bank_q;
        wcnt_d             = '0;
      end
    end

`ifdef IMGBUF_OVF_CHECK_EN
    if (close && at_end && !host_wlast) begin
      ovf_d  = 1'b1;
      drop_d = 1'b1;
    end
    if (beat && drop_q && host_wlast) begin
      drop_d = 1'b0;
    end
`endif

    // launch and done_ok need different rd_bank states, so never both.
    if (launch) begin
      state_d[rd_bank_q] = ACTIVE;
      mem_depth_d        = depth_q[rd_bank_q];
    end
    if (done_ok) begin
      state_d[rd_bank_q] = EMPTY;
      rd_bank_d          = ~rd_bank_q;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= EMPTY;
        depth_q[i] <= '0;
      end
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wcnt_q      <= '0;
      mem_depth_q <= '0;
`ifdef IMGBUF_OVF_CHECK_EN
      ovf_q       <= 1'b0;
      drop_q      <= 1'b0;
`endif
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        depth_q[i] <= depth_d[i];
      end
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wcnt_q      <= wcnt_d;
      mem_depth_q <= mem_depth_d;
`ifdef IMGBUF_OVF_CHECK_EN
      ovf_q       <= ovf_d;
      drop_q      <= drop_d;
`endif
    end
  end

`ifdef IMGBUF_OVF_CHECK_EN
  assign overflow_err = ovf_q;
`else
  assign overflow_err = 1'b0;
`endif

  assign bank_ready[0]  = (state_q[0] == READY) || (state_q[0] == ACTIVE);
  assign bank_ready[1]  = (state_q[1] == READY) || (state_q[1] == ACTIVE);
  assign dbg_bank_state = {state_q[1], state_q[0]};

  // ---------------------------------------------------------------------------
  // Bank storage and read path
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] b0_rdata0, b0_rdata1, b1_rdata0, b1_rdata1;
  logic [1:0]        we;
  logic              in_range0, in_range1;
  logic              ok0_q, ok1_q;
  logic              rsel_q;

  assign we[0] = store && !wr_bank_q;
  assign we[1] = store &&  wr_bank_q;

  dp_bank_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(RAM_AW)) u_bank0 (
    .clock  (clock),
    .we     (we[0]),
    .waddr  (wcnt_q[RAM_AW-1:0]),
    .wdata  (host_wdata),
    .raddr0 (input_mem_raddr0[RAM_AW-1:0]),
    .raddr1 (input_mem_raddr1[RAM_AW-1:0]),
    .rdata0 (b0_rdata0),
    .rdata1 (b0_rdata1)
  );

  dp_bank_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(RAM_AW)) u_bank1 (
    .clock  (clock),
    .we     (we[1]),
    .waddr  (wcnt_q[RAM_AW-1:0]),
    .wdata  (host_wdata),
    .raddr0 (input_mem_raddr0[RAM_AW-1:0]),
    .raddr1 (input_mem_raddr1[RAM_AW-1:0]),
    .rdata0 (b1_rdata0),
    .rdata1 (b1_rdata1)
  );

  assign in_range0 = ({1'b0, input_mem_raddr0} < DEPTH_W);
  assign in_range1 = ({1'b0, input_mem_raddr1} < DEPTH_W);

  // Bank select and range flags travel with the address so the output mux
  // lines up with the RAM's registered data. Clearing the flags in reset
  // forces rdata to 0 without resetting the storage.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ok0_q  <= 1'b0;
      ok1_q  <= 1'b0;
      rsel_q <= 1'b0;
    end else begin
      ok0_q  <= in_range0;
      ok1_q  <= in_range1;
      rsel_q <= rd_bank_q;
    end
  end

  assign input_mem_rdata0 = !ok0_q ? '0 : (rsel_q ? b1_rdata0 : b0_rdata0);
  assign input_mem_rdata1 = !ok1_q ? '0 : (rsel_q ? b1_rdata1 : b0_rdata1);

endmodule
